// File: rtl/fprint_pkg.sv
// Shared types and constants for the fingerprint comparator / release controller.
package fprint_pkg;
  localparam int KEY_W = 4;
  localparam int CRC_W = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPARE = 2'd1,
    FAULT   = 2'd2
  } state_t;

  localparam logic [1:0] FAULT_NONE     = 2'd0;
  localparam logic [1:0] FAULT_MISMATCH = 2'd1;
  localparam logic [1:0] FAULT_DUP      = 2'd2;
  localparam logic [1:0] FAULT_TIMEOUT  = 2'd3;
endpackage

// File: rtl/fprint_slot_table.sv
// Per-key fingerprint storage with independent A/B write ports and
// lowest-index encoders for complete and half-filled slots.
module fprint_slot_table
  import fprint_pkg::*;
#(
  parameter int NUM_KEYS = 16,
  parameter int CRC_W    = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             a_wr,
  input  logic [KEY_W-1:0] a_key,
  input  logic [CRC_W-1:0] a_crc,
  input  logic             b_wr,
  input  logic [KEY_W-1:0] b_key,
  input  logic [CRC_W-1:0] b_crc,
  input  logic             clr_en,
  input  logic [KEY_W-1:0] clr_key,
  input  logic             clr_all,
  input  logic [KEY_W-1:0] rd_key,
  output logic [CRC_W-1:0] rd_crc_a,
  output logic [CRC_W-1:0] rd_crc_b,
  output logic             a_dup,
  output logic             b_dup,
  output logic             both_any,
  output logic [KEY_W-1:0] both_idx,
  output logic             half_any,
  output logic [KEY_W-1:0] half_idx
);
  logic [NUM_KEYS-1:0] have_a, have_b;
  logic [NUM_KEYS-1:0] have_a_nxt, have_b_nxt;
  logic [NUM_KEYS-1:0] set_a, set_b, clr_mask;
  logic [NUM_KEYS-1:0] both_vec, half_vec;
  logic [CRC_W-1:0]    crc_a [NUM_KEYS];
  logic [CRC_W-1:0]    crc_b [NUM_KEYS];

  assign a_dup    = have_a[a_key];
  assign b_dup    = have_b[b_key];
  assign rd_crc_a = crc_a[rd_key];
  assign rd_crc_b = crc_b[rd_key];

  // A duplicate write leaves the stored CRC and have bit untouched.
  always_comb begin
    set_a    = '0;
    set_b    = '0;
    clr_mask = '0;
    if (a_wr && !a_dup) set_a[a_key] = 1'b1;
    if (b_wr && !b_dup) set_b[b_key] = 1'b1;
    if (clr_all)     clr_mask          = '1;
    else if (clr_en) clr_mask[clr_key] = 1'b1;
    have_a_nxt = (have_a | set_a) & ~clr_mask;
    have_b_nxt = (have_b | set_b) & ~clr_mask;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      have_a <= '0;
      have_b <= '0;
    end else begin
      have_a <= have_a_nxt;
      have_b <= have_b_nxt;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_KEYS; i++) begin
      if (set_a[i]) crc_a[i] <= a_crc;
      if (set_b[i]) crc_b[i] <= b_crc;
    end
  end

  // Completion is scanned on next-state bits so a slot finished this cycle
  // is compared on the very next one.
  assign both_vec = have_a_nxt & have_b_nxt;
  assign half_vec = have_a ^ have_b;

  always_comb begin
    both_any = 1'b0;
    both_idx = '0;
    half_any = 1'b0;
    half_idx = '0;
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (both_vec[i]) begin
        both_any = 1'b1;
        both_idx = KEY_W'(i);
      end
      if (half_vec[i]) begin
        half_any = 1'b1;
        half_idx = KEY_W'(i);
      end
    end
  end
endmodule

// File: rtl/fprint_release_ctrl.sv
// Compares redundant core fingerprints per task key and releases matching
// keys to the PIO; mismatch, duplicate or stalled partner latch a fault.
module fprint_release_ctrl
  import fprint_pkg::*;
#(
  parameter int NUM_KEYS = 16,
  parameter int CRC_W    = 32,
  parameter int TIMEOUT  = 1024
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             fp_a_valid,
  output logic             fp_a_ready,
  input  logic [KEY_W-1:0] fp_a_key,
  input  logic [CRC_W-1:0] fp_a_crc,
  input  logic             fp_b_valid,
  output logic             fp_b_ready,
  input  logic [KEY_W-1:0] fp_b_key,
  input  logic [CRC_W-1:0] fp_b_crc,
  output logic             io_release,
  output logic [KEY_W-1:0] io_key,
  output logic             fault_irq,
  output logic [1:0]       fault_code,
  output logic [KEY_W-1:0] fault_key,
  input  logic             irq_clear,
  output state_t           dbg_state
);
  localparam int WD_W = $clog2(TIMEOUT);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

  state_t           state, state_nxt;
  logic [KEY_W-1:0] cmp_key, cmp_key_nxt;
  logic [WD_W-1:0]  wd_cnt;
  logic             hs_a, hs_b, dup_a, dup_b, dup_hit, wd_hit;
  logic [KEY_W-1:0] dup_key;
  logic [CRC_W-1:0] rd_crc_a, rd_crc_b;
  logic             both_any, half_any;
  logic [KEY_W-1:0] both_idx, half_idx;
  logic             release_nxt, clr_en, clr_all, fault_set;
  logic [1:0]       fault_code_nxt;
  logic [KEY_W-1:0] fault_key_nxt;

  // Handshake: a fingerprint transfers in any cycle where valid && ready are
  // both high; ready depends only on the FSM state, never on valid.
  assign fp_a_ready = (state != FAULT);
  assign fp_b_ready = (state != FAULT);
  assign hs_a       = fp_a_valid && fp_a_ready;
  assign hs_b       = fp_b_valid && fp_b_ready;
  assign fault_irq  = (state == FAULT);
  assign dbg_state  = state;

  fprint_slot_table #(.NUM_KEYS(NUM_KEYS), .CRC_W(CRC_W)) u_slots (
    .clk      (clk),
    .reset_n  (reset_n),
    .a_wr     (hs_a),
    .a_key    (fp_a_key),
    .a_crc    (fp_a_crc),
    .b_wr     (hs_b),
    .b_key    (fp_b_key),
    .b_crc    (fp_b_crc),
    .clr_en   (clr_en),
    .clr_key  (cmp_key),
    .clr_all  (clr_all),
    .rd_key   (cmp_key),
    .rd_crc_a (rd_crc_a),
    .rd_crc_b (rd_crc_b),
    .a_dup    (dup_a),
    .b_dup    (dup_b),
    .both_any (both_any),
    .both_idx (both_idx),
    .half_any (half_any),
    .half_idx (half_idx)
  );

  assign dup_hit = (hs_a && dup_a) || (hs_b && dup_b);
  assign dup_key = (hs_a && dup_a) ? fp_a_key : fp_b_key;
  assign wd_hit  = half_any && (wd_cnt == WD_LAST);

  always_comb begin
    state_nxt      = state;
    cmp_key_nxt    = cmp_key;
    release_nxt    = 1'b0;
    clr_en         = 1'b0;
    clr_all        = 1'b0;
    fault_set      = 1'b0;
    fault_code_nxt = FAULT_NONE;
    fault_key_nxt  = '0;
    case (state)
      IDLE: begin
        if (dup_hit) begin
          fault_set = 1'b1; fault_code_nxt = FAULT_DUP; fault_key_nxt = dup_key;
        end else if (wd_hit) begin
          fault_set = 1'b1; fault_code_nxt = FAULT_TIMEOUT; fault_key_nxt = half_idx;
        end else if (both_any) begin
          state_nxt   = COMPARE;
          cmp_key_nxt = both_idx;
        end
      end
      COMPARE: begin
        // A fault raised in the compare cycle suppresses the release.
        if (rd_crc_a != rd_crc_b) begin
          fault_set = 1'b1; fault_code_nxt = FAULT_MISMATCH; fault_key_nxt = cmp_key;
        end else if (dup_hit) begin
          fault_set = 1'b1; fault_code_nxt = FAULT_DUP; fault_key_nxt = dup_key;
        end else if (wd_hit) begin
          fault_set = 1'b1; fault_code_nxt = FAULT_TIMEOUT; fault_key_nxt = half_idx;
        end else begin
          release_nxt = 1'b1;
          clr_en      = 1'b1;
          state_nxt   = IDLE;
        end
      end
      FAULT: begin
        if (irq_clear) begin
          clr_all   = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (fault_set) state_nxt = FAULT;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      cmp_key    <= '0;
      io_release <= 1'b0;
      io_key     <= '0;
      fault_code <= FAULT_NONE;
      fault_key  <= '0;
    end else begin
      state      <= state_nxt;
      cmp_key    <= cmp_key_nxt;
      io_release <= release_nxt;
      if (release_nxt) io_key <= cmp_key;
      if (fault_set) begin
        fault_code <= fault_code_nxt;
        fault_key  <= fault_key_nxt;
      end else if (clr_all) begin
        fault_code <= FAULT_NONE;
        fault_key  <= '0;
      end
    end
  end

  // Watchdog is frozen while faulted so the recorded state stays inspectable.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wd_cnt <= '0;
    end else if (state == FAULT) begin
      if (irq_clear) wd_cnt <= '0;
    end else if (release_nxt || !half_any) begin
      wd_cnt <= '0;
    end else if (wd_cnt != WD_LAST) begin
      wd_cnt <= wd_cnt + WD_W'(1);
    end
  end
endmodule

// File: tb/tb_fprint_release_ctrl.sv
// Directed bench for fprint_release_ctrl: drivers push expected release/fault
// events, a negedge monitor pops and compares them as the DUT produces them.
module tb_fprint_release_ctrl;
  import fprint_pkg::*;

  localparam int TIMEOUT = 16;
  localparam int EW      = 23;  // {kind, code[1:0], key[3:0], cycle[15:0]}

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        fp_a_valid = 1'b0, fp_b_valid = 1'b0;
  logic        fp_a_ready, fp_b_ready;
  logic [3:0]  fp_a_key = '0, fp_b_key = '0;
  logic [31:0] fp_a_crc = '0, fp_b_crc = '0;
  logic        io_release, fault_irq;
  logic [3:0]  io_key, fault_key;
  logic [1:0]  fault_code;
  logic        irq_clear = 1'b0;
  state_t      dbg_state;

  int unsigned cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;
  logic [EW-1:0] exp_q[$];
  logic        fault_seen = 1'b0;
  int unsigned c;

  fprint_release_ctrl #(.NUM_KEYS(16), .CRC_W(32), .TIMEOUT(TIMEOUT)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .fp_a_valid (fp_a_valid),
    .fp_a_ready (fp_a_ready),
    .fp_a_key   (fp_a_key),
    .fp_a_crc   (fp_a_crc),
    .fp_b_valid (fp_b_valid),
    .fp_b_ready (fp_b_ready),
    .fp_b_key   (fp_b_key),
    .fp_b_crc   (fp_b_crc),
    .io_release (io_release),
    .io_key     (io_key),
    .fault_irq  (fault_irq),
    .fault_code (fault_code),
    .fault_key  (fault_key),
    .irq_clear  (irq_clear),
    .dbg_state  (dbg_state)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [EW-1:0] ev(input logic kind, input logic [1:0] code,
                                       input logic [3:0] key, input int unsigned at);
    logic [15:0] at16;
    at16 = at[15:0];
    return {kind, code, key, at16};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic mon_event(input string name, input logic [EW-1:0] act);
    logic [EW-1:0] e;
    n_checks++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL %s: unexpected event 0x%0h at cycle %0d, required none", name, act, cyc);
    end else begin
      e = exp_q.pop_front();
      if (act !== e) begin
        n_fail++;
        $display("FAIL %s: got kind/code/key/cycle 0x%0h, required 0x%0h", name, act, e);
      end
    end
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (reset_n) begin
      if (io_release) mon_event("release", ev(1'b0, 2'd0, io_key, cyc));
      if (fault_irq && !fault_seen) mon_event("fault", ev(1'b1, fault_code, fault_key, cyc));
    end
    fault_seen <= fault_irq;
  end

  // driver tasks: entered and left at posedge + 1
  task automatic drive(input logic a_en, input logic [3:0] a_key, input logic [31:0] a_crc,
                       input logic b_en, input logic [3:0] b_key, input logic [31:0] b_crc);
    fp_a_valid = a_en; fp_a_key = a_key; fp_a_crc = a_crc;
    fp_b_valid = b_en; fp_b_key = b_key; fp_b_crc = b_crc;
    if (a_en) check("a_ready_at_handshake", {31'd0, fp_a_ready}, 32'd1);
    if (b_en) check("b_ready_at_handshake", {31'd0, fp_b_ready}, 32'd1);
    @(posedge clk); #1;
    fp_a_valid = 1'b0;
    fp_b_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic pulse_clear();
    irq_clear = 1'b1;
    @(posedge clk); #1;
    irq_clear = 1'b0;
  endtask

  task automatic drain(input int budget);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < budget) begin
      @(posedge clk); #1;
      k++;
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d events pending after %0d cycles, required 0", exp_q.size(), budget);
      exp_q.delete();
    end
  endtask

  task automatic check_slots_empty(input string name);
    check(name, {dut.u_slots.have_a, dut.u_slots.have_b}, 32'd0);
  endtask

  initial begin
    // reset
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    idle(1);
    check("rst_io_release", {31'd0, io_release}, 32'd0);
    check("rst_io_key", {28'd0, io_key}, 32'd0);
    check("rst_fault_irq", {31'd0, fault_irq}, 32'd0);
    check("rst_fault_code", {30'd0, fault_code}, 32'd0);
    check("rst_fault_key", {28'd0, fault_key}, 32'd0);
    check("rst_ready", {30'd0, fp_a_ready, fp_b_ready}, 32'd3);
    check("rst_state", {30'd0, dbg_state}, 32'd0);

    // key 3: A first, B two cycles later
    drive(1'b1, 4'd3, 32'hDEADBEEF, 1'b0, 4'd0, 32'd0);
    idle(1);
    c = cyc;
    exp_q.push_back(ev(1'b0, 2'd0, 4'd3, c + 2));
    drive(1'b0, 4'd0, 32'd0, 1'b1, 4'd3, 32'hDEADBEEF);
    drain(10);
    check_slots_empty("slot3_empty");
    check("idle_after_release", {30'd0, dbg_state}, 32'd0);

    // keys 2 and 9 completed in the same cycle
    drive(1'b1, 4'd2, 32'h22, 1'b1, 4'd9, 32'h99);
    c = cyc;
    exp_q.push_back(ev(1'b0, 2'd0, 4'd2, c + 2));
    exp_q.push_back(ev(1'b0, 2'd0, 4'd9, c + 4));
    drive(1'b1, 4'd9, 32'h99, 1'b1, 4'd2, 32'h22);
    drain(12);
    check_slots_empty("slots_2_9_empty");

    // boundary keys 0 and 15 with all-ones / all-zeros CRCs
    drive(1'b1, 4'd0, 32'hFFFFFFFF, 1'b1, 4'd15, 32'h0);
    c = cyc;
    exp_q.push_back(ev(1'b0, 2'd0, 4'd0, c + 2));
    exp_q.push_back(ev(1'b0, 2'd0, 4'd15, c + 4));
    drive(1'b1, 4'd15, 32'h0, 1'b1, 4'd0, 32'hFFFFFFFF);
    drain(12);

    // mismatch on key 5
    c = cyc;
    exp_q.push_back(ev(1'b1, FAULT_MISMATCH, 4'd5, c + 2));
    drive(1'b1, 4'd5, 32'h1234, 1'b1, 4'd5, 32'h1235);
    drain(10);
    check("mm_fault_irq", {31'd0, fault_irq}, 32'd1);
    check("mm_fault_code", {30'd0, fault_code}, 32'd1);
    check("mm_fault_key", {28'd0, fault_key}, 32'd5);
    check("mm_ready", {30'd0, fp_a_ready, fp_b_ready}, 32'd0);
    check("mm_slot5_kept", {30'd0, dut.u_slots.have_a[5], dut.u_slots.have_b[5]}, 32'd3);
    pulse_clear();
    check("clr_fault_irq", {31'd0, fault_irq}, 32'd0);
    check("clr_ready", {30'd0, fp_a_ready, fp_b_ready}, 32'd3);
    check("clr_fault_code", {30'd0, fault_code}, 32'd0);
    check("clr_state", {30'd0, dbg_state}, 32'd0);
    check_slots_empty("clr_slots_empty");

    // duplicate A submission on key 7
    drive(1'b1, 4'd7, 32'h77, 1'b0, 4'd0, 32'd0);
    c = cyc;
    exp_q.push_back(ev(1'b1, FAULT_DUP, 4'd7, c + 1));
    drive(1'b1, 4'd7, 32'h78, 1'b0, 4'd0, 32'd0);
    drain(10);
    check("dup_fault_code", {30'd0, fault_code}, 32'd2);
    pulse_clear();

    // irq_clear outside FAULT must not drop a half-filled slot
    drive(1'b1, 4'd6, 32'hCAFE0006, 1'b0, 4'd0, 32'd0);
    pulse_clear();
    c = cyc;
    exp_q.push_back(ev(1'b0, 2'd0, 4'd6, c + 2));
    drive(1'b0, 4'd0, 32'd0, 1'b1, 4'd6, 32'hCAFE0006);
    drain(10);
    check("io_key_holds", {28'd0, io_key}, 32'd6);

    // watchdog timeout on a lone A for key 4, then reset mid-fault
    c = cyc;
    exp_q.push_back(ev(1'b1, FAULT_TIMEOUT, 4'd4, c + TIMEOUT + 1));
    drive(1'b1, 4'd4, 32'h44, 1'b0, 4'd0, 32'd0);
    drain(TIMEOUT + 10);
    check("to_fault_code", {30'd0, fault_code}, 32'd3);
    #2 reset_n = 1'b0;
    #1;
    check("mid_rst_io_release", {31'd0, io_release}, 32'd0);
    check("mid_rst_io_key", {28'd0, io_key}, 32'd0);
    check("mid_rst_fault_irq", {31'd0, fault_irq}, 32'd0);
    check("mid_rst_fault_code", {30'd0, fault_code}, 32'd0);
    check("mid_rst_fault_key", {28'd0, fault_key}, 32'd0);
    check_slots_empty("mid_rst_slots_empty");
    #2 reset_n = 1'b1;
    @(posedge clk); #1;

    // normal release after reset
    c = cyc;
    exp_q.push_back(ev(1'b0, 2'd0, 4'd1, c + 2));
    drive(1'b1, 4'd1, 32'h0BADF00D, 1'b1, 4'd1, 32'h0BADF00D);
    drain(10);
    idle(4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
